// File: rtl/row_scan_seq_pkg.sv
// Shared types and row-geometry constants for the row-scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK
    } scan_state_t;

    localparam int ADDR_W   = 4;
    localparam int N_ROWS   = 16;
    localparam int LAST_ROW = N_ROWS - 1;

endpackage

// File: rtl/row_scan_seq_timer.sv
// Loadable down-counter; zero marks the final cycle of the loaded interval.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/row_scan_seq.sv
// Row-scan sequencer driving a 4-to-16 decoder: dwell per row, blanking
// between rows, single-shot or continuous, with abort and completion pulse.
module row_scan_seq
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0]  addr,
    output logic               en,
    output logic               row_strobe,
    output logic               busy,
    output logic               done
);

    // Timer must also hold BLANK_CYC-1 (up to 14), hence at least 4 bits.
    localparam int TW = (DWELL_W > 4) ? DWELL_W : 4;
    localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ROW);

    scan_state_t        state;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;
    logic [DWELL_W-1:0] dwell_eff;
    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_zero;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // The timer is loaded with interval-1 so that zero flags the last cycle.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(dwell_eff) - TW'(1);
                end
            end
            ACTIVE: begin
                if (!stop && tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LD;
                end
            end
            BLANK: begin
                if (!stop && tmr_zero && (addr != LAST_A || cont_q)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(dwell_q) - TW'(1);
                end
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    scan_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            en         <= 1'b0;
            row_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dwell_q    <= DWELL_W'(1);
            cont_q     <= 1'b0;
        end else begin
            row_strobe <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state      <= ACTIVE;
                        dwell_q    <= dwell_eff;
                        cont_q     <= mode_cont;
                        addr       <= '0;
                        en         <= 1'b1;
                        busy       <= 1'b1;
                        row_strobe <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        state <= IDLE;
                        addr  <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (tmr_zero) begin
                        state <= BLANK;
                        en    <= 1'b0;
                    end
                end
                BLANK: begin
                    if (stop) begin
                        state <= IDLE;
                        addr  <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (tmr_zero) begin
                        if (addr == LAST_A && !cont_q) begin
                            state <= IDLE;
                            addr  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // 4-bit increment wraps 15 -> 0 in continuous mode.
                            state      <= ACTIVE;
                            addr       <= addr + 1'b1;
                            en         <= 1'b1;
                            row_strobe <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    addr  <= '0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
